elevator_request_arbiter: RTL and testbench
===========================================

Name: elevator_request_arbiter

Overview:
Collects hall/cabin floor-button presses into a pending-request vector and drives the next target floor (req_floor) consumed by the elevator FSM. Uses a SCAN (collective) policy: keep the current direction while requests lie ahead, reverse only when none do. Retires requests using the FSM's one-hot request_done. Sits between the button inputs and the elevator FSM, sharing curr_floor, req_floor and request_done with it.

Parameters:
FLOORS_NUM, 5, number of floors; FW = $clog2(FLOORS_NUM) is the floor-index width.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  FLOORS_NUM  button request per floor; bit i high for ≥1 cycle requests floor i (level or pulse, sampled every cycle)
curr_floor  input  FW  current floor from elevator FSM
request_done  input  FLOORS_NUM  one-hot from FSM, high for whole door-open period at the served floor
req_floor  output  FW  registered target floor to FSM
pending  output  FLOORS_NUM  registered outstanding-request vector
dir  output  2  registered direction state: 00 idle, 01 up, 10 down

Behaviour:
- Reset (async, rst_n=0): pending=0, req_floor=0, dir=00 (A_IDLE). Reset mid-operation drops all requests immediately; the FSM sees req_floor=0 after reset.
- Pending update, each edge: pending <= (pending | btn_eff) & ~request_done.
  - btn_eff = btn, except bit curr_floor is masked while in A_IDLE (a press at the floor the car is parked at is discarded, never latched).
  - Same-cycle btn[i] and request_done[i]: clear wins, so bit i stays 0.
- Classification uses registered pending and curr_floor:
  - above = pending bits with index > curr_floor.
  - below = pending bits with index < curr_floor.
  - A bit equal to curr_floor outside A_IDLE is neither above nor below; it is served on a later pass.
- State machine (dir):
  - A_IDLE: above≠0 and below=0 -> A_UP. below≠0 and above=0 -> A_DOWN. Both nonzero -> toward the nearest pending floor; equal distance -> A_UP. Otherwise stay. Also clears pending[curr_floor] if set.
  - A_UP: above≠0 -> stay. above=0 and below≠0 -> A_DOWN. Both 0 -> A_IDLE.
  - A_DOWN: below≠0 -> stay. below=0 and above≠0 -> A_UP. Both 0 -> A_IDLE.
- Target, computed from the next state and registered together with dir:
  - A_UP: lowest set index in above.
  - A_DOWN: highest set index in below.
  - A_IDLE: curr_floor, which holds the FSM in idle.
- Latency: btn at edge N -> pending at N; dir/req_floor reflect it at N+1. request_done at edge N clears pending at N; dir/req_floor update at N+1.
- Invariant: while the car moves up, req_floor > curr_floor and never switches to a floor below. A new nearer request ahead retargets req_floor immediately; a request behind does not change req_floor.
- Integration constraint: FSM door-open time ≥3 cycles, so req_floor is settled before the FSM leaves its door state.
- Out-of-range bits (index ≥ FLOORS_NUM) do not exist; the arbiter never outputs req_floor ≥ FLOORS_NUM.
- A frozen FSM (stop) needs no special handling: requests keep accumulating and targets keep updating.

Test Plan:
1. Assert rst_n=0 mid-run with pending=10110 -> pending=00000, req_floor=0, dir=00 asynchronously; after release, stays idle with btn=0.
2. curr_floor=0, idle, btn=01000 for one cycle -> pending=01000 at the next edge; one edge later dir=01, req_floor=3.
3. Moving up, curr_floor=1, target 3: press btn[2] -> req_floor=2 one cycle after pending; press btn[0] -> req_floor stays 3 and pending bit0 is set.
4. With pending=01101 and curr_floor=2: request_done=00100 -> pending=01001, dir=01, req_floor=3. Then curr_floor=3 and request_done=01000 -> pending=00001, dir=10, req_floor=0. Then curr_floor=0 and request_done=00001 -> dir=00, req_floor=0.
5. Idle at curr_floor=2: btn=10001 (distance tie) -> dir=01, req_floor=4. Separately, btn=10010 -> dir=10, req_floor=1.
6. Idle at curr_floor=2, btn=00100 -> pending stays 00000. During the door at floor 2 (request_done=00100), btn[2]=1 -> pending bit2 stays 0.

Source files
------------

// File: rtl/elevator_request_arbiter_if.sv
// Button/FSM-facing signal bundle for the elevator request arbiter.
// master: button/FSM side driving requests and floor; slave: the arbiter.
interface elevator_request_arbiter_if #(
  parameter int FLOORS_NUM = 5,
  parameter int FW = (FLOORS_NUM > 1) ? $clog2(FLOORS_NUM) : 1
);
  logic [FLOORS_NUM-1:0] btn;
  logic [FW-1:0]         curr_floor;
  logic [FLOORS_NUM-1:0] request_done;
  logic [FW-1:0]         req_floor;
  logic [FLOORS_NUM-1:0] pending;
  logic [1:0]            dir;

  modport master (
    output btn, curr_floor, request_done,
    input  req_floor, pending, dir
  );

  modport slave (
    input  btn, curr_floor, request_done,
    output req_floor, pending, dir
  );
endinterface

// File: rtl/elevator_request_arbiter.sv
// SCAN-policy floor request arbiter: latches buttons, retires on request_done, picks next target.
// btn/request_done hit pending at the same edge; dir/req_floor follow one edge later; no backpressure.
module elevator_request_arbiter #(
  parameter int FLOORS_NUM = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  elevator_request_arbiter_if.slave arb
);
  localparam int FW = (FLOORS_NUM > 1) ? $clog2(FLOORS_NUM) : 1;

  typedef enum logic [1:0] {
    A_IDLE = 2'b00,
    A_UP   = 2'b01,
    A_DOWN = 2'b10
  } dir_t;

  dir_t                  state;
  logic [FW-1:0]         req_floor_q;
  logic [FLOORS_NUM-1:0] pending_q;

  logic [FLOORS_NUM-1:0] cur_oh;
  logic [FLOORS_NUM-1:0] above;
  logic [FLOORS_NUM-1:0] below;
  logic [FLOORS_NUM-1:0] pending_nxt;
  logic [FW-1:0]         lo_above;
  logic [FW-1:0]         hi_below;
  logic [FW-1:0]         d_up;
  logic [FW-1:0]         d_down;
  logic [FW-1:0]         idle_tgt;
  logic                  any_above;
  logic                  any_below;

  always_comb begin
    cur_oh   = '0;
    above    = '0;
    below    = '0;
    lo_above = '0;
    hi_below = '0;
    for (int i = 0; i < FLOORS_NUM; i++) begin
      cur_oh[i] = (i == int'(arb.curr_floor));
      above[i]  = pending_q[i] & (i > int'(arb.curr_floor));
      below[i]  = pending_q[i] & (i < int'(arb.curr_floor));
    end
    // Scan downward so the last hit is the lowest floor ahead when going up.
    for (int i = FLOORS_NUM - 1; i >= 0; i--) begin
      if (above[i]) lo_above = FW'(i);
    end
    for (int i = 0; i < FLOORS_NUM; i++) begin
      if (below[i]) hi_below = FW'(i);
    end
    any_above = |above;
    any_below = |below;
    d_up      = lo_above - arb.curr_floor;
    d_down    = arb.curr_floor - hi_below;
    idle_tgt  = (int'(arb.curr_floor) < FLOORS_NUM) ? arb.curr_floor : '0;
    // Parked car swallows presses at its own floor; clear beats a same-cycle press.
    pending_nxt = (pending_q | arb.btn) & ~arb.request_done
                  & ~((state == A_IDLE) ? cur_oh : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= A_IDLE;
      req_floor_q <= '0;
      pending_q   <= '0;
    end else begin
      pending_q <= pending_nxt;
      case (state)
        A_IDLE: begin
          if (any_above && (!any_below || d_up <= d_down)) begin
            state       <= A_UP;
            req_floor_q <= lo_above;
          end else if (any_below) begin
            state       <= A_DOWN;
            req_floor_q <= hi_below;
          end else begin
            state       <= A_IDLE;
            req_floor_q <= idle_tgt;
          end
        end
        A_UP: begin
          if (any_above) begin
            state       <= A_UP;
            req_floor_q <= lo_above;
          end else if (any_below) begin
            state       <= A_DOWN;
            req_floor_q <= hi_below;
          end else begin
            state       <= A_IDLE;
            req_floor_q <= idle_tgt;
          end
        end
        A_DOWN: begin
          if (any_below) begin
            state       <= A_DOWN;
            req_floor_q <= hi_below;
          end else if (any_above) begin
            state       <= A_UP;
            req_floor_q <= lo_above;
          end else begin
            state       <= A_IDLE;
            req_floor_q <= idle_tgt;
          end
        end
        default: begin
          state       <= A_IDLE;
          req_floor_q <= idle_tgt;
        end
      endcase
    end
  end

  assign arb.pending   = pending_q;
  assign arb.req_floor = req_floor_q;
  assign arb.dir       = state;
endmodule

// File: tb/tb_elevator_request_arbiter.sv
// Directed bench for elevator_request_arbiter with hand-computed expectations.
module tb_elevator_request_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  elevator_request_arbiter_if #(.FLOORS_NUM(5)) ifc ();

  elevator_request_arbiter #(.FLOORS_NUM(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_p(input string tag, input logic [4:0] exp);
    total++;
    assert (ifc.pending === exp) else begin
      bad++;
      $error("FAIL %s pending got=%b want=%b", tag, ifc.pending, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [2:0] exp);
    total++;
    assert (ifc.req_floor === exp) else begin
      bad++;
      $error("FAIL %s req_floor got=%0d want=%0d", tag, ifc.req_floor, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [1:0] exp);
    total++;
    assert (ifc.dir === exp) else begin
      bad++;
      $error("FAIL %s dir got=%b want=%b", tag, ifc.dir, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifc.btn          = 5'b00000;
    ifc.curr_floor   = 3'd0;
    ifc.request_done = 5'b00000;
    #1;
    chk_p("rst_pending", 5'b00000);
    chk_r("rst_req", 3'd0);
    chk_d("rst_dir", 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_d("idle_after_rst", 2'b00);

    // Single press above the parked car.
    ifc.btn = 5'b01000;
    tick();
    chk_p("press3_pending", 5'b01000);
    chk_d("press3_dir_lag", 2'b00);
    ifc.btn = 5'b00000;
    tick();
    chk_d("press3_dir", 2'b01);
    chk_r("press3_req", 3'd3);

    // Moving up from floor 1: nearer floor ahead retargets, floor behind does not.
    ifc.curr_floor = 3'd1;
    tick();
    ifc.btn = 5'b00100;
    tick();
    chk_p("press2_pending", 5'b01100);
    chk_r("press2_req_lag", 3'd3);
    ifc.btn = 5'b00000;
    tick();
    chk_r("press2_req", 3'd2);
    ifc.btn = 5'b00001;
    tick();
    chk_p("press0_pending", 5'b01101);
    ifc.btn = 5'b00000;
    tick();
    chk_r("press0_req", 3'd2);
    chk_d("press0_dir", 2'b01);

    // Serve floor 2, then 3 (reversal), then 0 (back to idle).
    ifc.curr_floor   = 3'd2;
    ifc.request_done = 5'b00100;
    tick();
    chk_p("done2_pending", 5'b01001);
    ifc.request_done = 5'b00000;
    tick();
    chk_d("done2_dir", 2'b01);
    chk_r("done2_req", 3'd3);
    ifc.curr_floor   = 3'd3;
    ifc.request_done = 5'b01000;
    tick();
    chk_p("done3_pending", 5'b00001);
    chk_d("done3_dir", 2'b10);
    chk_r("done3_req", 3'd0);
    ifc.request_done = 5'b00000;
    tick();
    ifc.curr_floor   = 3'd0;
    ifc.request_done = 5'b00001;
    tick();
    chk_p("done0_pending", 5'b00000);
    chk_d("done0_dir", 2'b00);
    chk_r("done0_req", 3'd0);
    ifc.request_done = 5'b00000;

    // Idle at floor 2 with a distance tie: up wins.
    ifc.curr_floor = 3'd2;
    tick();
    chk_r("idle2_req", 3'd2);
    ifc.btn = 5'b10001;
    tick();
    ifc.btn = 5'b00000;
    tick();
    chk_d("tie_dir", 2'b01);
    chk_r("tie_req", 3'd4);
    ifc.request_done = 5'b10001;
    tick();
    ifc.request_done = 5'b00000;
    tick();
    chk_d("tie_cleared_dir", 2'b00);
    chk_r("tie_cleared_req", 3'd2);

    // Nearer request below wins.
    ifc.btn = 5'b10010;
    tick();
    ifc.btn = 5'b00000;
    tick();
    chk_d("near_dir", 2'b10);
    chk_r("near_req", 3'd1);
    ifc.request_done = 5'b10010;
    tick();
    ifc.request_done = 5'b00000;
    tick();
    chk_d("near_cleared_dir", 2'b00);

    // Press at the parked floor is discarded.
    ifc.btn = 5'b00100;
    tick();
    chk_p("park_press_pending", 5'b00000);
    ifc.btn = 5'b00000;
    tick();
    chk_d("park_press_dir", 2'b00);

    // Leave idle (going down to 0), then door at 2 with a press there: clear wins.
    ifc.btn = 5'b00001;
    tick();
    ifc.btn = 5'b00000;
    tick();
    chk_d("down0_dir", 2'b10);
    ifc.btn          = 5'b00100;
    ifc.request_done = 5'b00100;
    tick();
    chk_p("clear_wins_pending", 5'b00001);
    ifc.btn          = 5'b00000;
    ifc.request_done = 5'b00000;

    // Build 10110 mid-run, then reset asynchronously between edges.
    ifc.btn          = 5'b10110;
    ifc.request_done = 5'b00001;
    tick();
    chk_p("pre_rst_pending", 5'b10110);
    ifc.btn          = 5'b00000;
    ifc.request_done = 5'b00000;
    ifc.curr_floor   = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_p("async_rst_pending", 5'b00000);
    chk_r("async_rst_req", 3'd0);
    chk_d("async_rst_dir", 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_p("post_rst_pending", 5'b00000);
    chk_d("post_rst_dir", 2'b00);
    chk_r("post_rst_req", 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
